regs_mp: RTL and testbench

Parametrised multi-read-port register file, successor to the picoMIPS 32 x n register file.
- Generalised in width, depth and read-port count.
- Dedicated write-address port, no longer shared with a read port.
- Optional hardwired-zero register.
- Synchronous-reset clear sweep, so the array maps to FPGA RAM/LUTRAM without an array-wide reset.
- Sits between decode and the ALU in the picoMIPS datapath.

---
 rtl/regs_pkg.sv | 17 +
 rtl/regs_clr_fsm.sv | 70 +++++++
 rtl/regs_mp.sv | 85 ++++++++
 tb/tb_regs_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared types and helpers for the regs_mp multi-read-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regs_pkg;

    // Clear sweep in progress, or normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regs_state_t;

    // Address width for a given register count; never less than one bit.
    function automatic int regs_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regs_clr_fsm.sv
// Post-reset clear sequencer: walks every register address once, then raises ready.
// Latency: DEPTH cycles after reset falls; ready is registered and first high in cycle DEPTH+1.
// Backpressure: none; reset at any edge restarts the sweep from address 0.
module regs_clr_fsm
    import regs_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = regs_aw(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    regs_state_t   r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;

    regs_state_t   w_state_nxt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_ready_nxt;

    // State register: reset forces a fresh sweep from address 0 with ready low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next state: advance the sweep; the counter stops at the last address, never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        case (r_state)
            CLEAR: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Outputs: clear write is suppressed on a reset edge so reset never touches the array.
    always_comb begin
        o_clr_we   = (r_state == CLEAR) && !i_reset;
        o_clr_addr = r_cnt;
        o_ready    = r_ready;
    end

endmodule

// File: rtl/regs_mp.sv
// Parametrised register file: one write port, NRD combinational read ports, optional zero register.
// Latency: reads are zero-latency; writes are visible the cycle after the edge (same cycle with REGS_BYPASS_EN).
// Backpressure: none; user writes are silently dropped and reads return 0 until ready is high.
module regs_mp
    import regs_pkg::*;
#(
    parameter int N        = 8,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = regs_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w,
    input  logic [AW-1:0] Waddr,
    input  logic [N-1:0]  Wdata,
    input  logic [AW-1:0] Raddr [NRD],
    output logic [N-1:0]  Rdata [NRD],
    output logic          ready
);

    logic [N-1:0]  r_gpr [DEPTH];

    logic          w_ready;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_user_we;
    logic          w_arr_we;
    logic [AW-1:0] w_arr_addr;
    logic [N-1:0]  w_arr_data;

    regs_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .i_clk      (clk),
        .i_reset    (reset),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_ready)
    );

    assign ready = w_ready;

    // Single array write port: the clear sweep owns it until ready, then the user port does.
    always_comb begin
        w_user_we = w && w_ready && !reset && !((ZERO_REG != 0) && (Waddr == '0));
        if (w_clr_we) begin
            w_arr_we   = 1'b1;
            w_arr_addr = w_clr_addr;
            w_arr_data = '0;
        end else begin
            w_arr_we   = w_user_we;
            w_arr_addr = Waddr;
            w_arr_data = Wdata;
        end
    end

    // Storage array: no reset term so it can map onto RAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_gpr[w_arr_addr] <= w_arr_data;
        end
    end

    // Read ports: forced to 0 during the sweep and for the hardwired zero register.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            Rdata[k] = '0;
            if (w_ready && !((ZERO_REG != 0) && (Raddr[k] == '0))) begin
`ifdef REGS_BYPASS_EN
                if (w_user_we && (Raddr[k] == Waddr)) begin
                    Rdata[k] = Wdata;
                end else begin
                    Rdata[k] = r_gpr[Raddr[k]];
                end
`else
                Rdata[k] = r_gpr[Raddr[k]];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: default build, a ZERO_REG=0 twin and a 16x16 four-port build.
// Expected values are hand-computed vectors plus a small scoreboard for the fill tests.
// Same-cycle read/write expectations follow REGS_BYPASS_EN when it is defined.
module tb_regs_mp;

`ifdef REGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default (A) and ZERO_REG=0 (Z) instances.
    logic       rst;
    logic       w;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic [4:0] ra   [2];
    logic [7:0] rd_a [2];
    logic [7:0] rd_z [2];
    logic       rdy_a, rdy_z;

    // Stimulus for the 16-bit, 16-deep, 4-port instance (B).
    logic        rst_b;
    logic        w_b;
    logic [3:0]  wa_b;
    logic [15:0] wd_b;
    logic [3:0]  ra_b [4];
    logic [15:0] rd_b [4];
    logic        rdy_b;

    regs_mp #(.N(8), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(rst), .w(w), .Waddr(waddr), .Wdata(wdata),
        .Raddr(ra), .Rdata(rd_a), .ready(rdy_a)
    );

    regs_mp #(.N(8), .DEPTH(32), .NRD(2), .ZERO_REG(0)) dut_z (
        .clk(clk), .reset(rst), .w(w), .Waddr(waddr), .Wdata(wdata),
        .Raddr(ra), .Rdata(rd_z), .ready(rdy_z)
    );

    regs_mp #(.N(16), .DEPTH(16), .NRD(4), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(rst_b), .w(w_b), .Waddr(wa_b), .Wdata(wd_b),
        .Raddr(ra_b), .Rdata(rd_b), .ready(rdy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       w;
        logic [4:0] waddr;
        logic [7:0] wdata;
        logic [4:0] ra0;
        logic [4:0] ra1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] ez0;
        logic [7:0] ez1;
    } vec_t;

    vec_t vecs [10];

    logic [15:0] sb_b [16];

    initial begin
        // Vector table, one clock each; outputs are checked before the edge that commits the write.
        vecs[0] = '{1'b0, 5'd5, 8'h00, 5'd5, 5'd5, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 5'd5, 8'hA5, 5'd5, 5'd5,
                    BYP ? 8'hA5 : 8'h00, BYP ? 8'hA5 : 8'h00,
                    BYP ? 8'hA5 : 8'h00, BYP ? 8'hA5 : 8'h00};
        vecs[2] = '{1'b0, 5'd0, 8'h00, 5'd5, 5'd5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vecs[3] = '{1'b1, 5'd0, 8'hFF, 5'd0, 5'd5, 8'h00, 8'hA5, BYP ? 8'hFF : 8'h00, 8'hA5};
        vecs[4] = '{1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 8'h00, 8'h00, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 5'd7, 8'h11, 5'd7, 5'd7,
                    BYP ? 8'h11 : 8'h00, BYP ? 8'h11 : 8'h00,
                    BYP ? 8'h11 : 8'h00, BYP ? 8'h11 : 8'h00};
        vecs[6] = '{1'b1, 5'd7, 8'h3C, 5'd7, 5'd5,
                    BYP ? 8'h3C : 8'h11, 8'hA5, BYP ? 8'h3C : 8'h11, 8'hA5};
        vecs[7] = '{1'b0, 5'd0, 8'h00, 5'd7, 5'd7, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        vecs[8] = '{1'b1, 5'd9, 8'h77, 5'd9, 5'd7,
                    BYP ? 8'h77 : 8'h00, 8'h3C, BYP ? 8'h77 : 8'h00, 8'h3C};
        vecs[9] = '{1'b0, 5'd0, 8'h00, 5'd9, 5'd0, 8'h77, 8'h00, 8'h77, 8'hFF};

        rst = 1'b1; w = 1'b1; waddr = 5'd5; wdata = 8'h99;
        ra[0] = 5'd0; ra[1] = 5'd0;
        rst_b = 1'b1; w_b = 1'b0; wa_b = '0; wd_b = '0;
        for (int k = 0; k < 4; k++) ra_b[k] = '0;

        // Reset held 3 cycles (with a write attempt), then the 32-cycle sweep with ready low.
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready_a", 32'(rdy_a), 32'd0);
        check("reset_ready_z", 32'(rdy_z), 32'd0);
        rst = 1'b0; w = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(31 - i);
            if (i == 20) begin
                w = 1'b1; waddr = 5'd5; wdata = 8'h5A;
            end else begin
                w = 1'b0;
            end
            #1;
            check($sformatf("sweep_ready_a[%0d]", i), 32'(rdy_a), 32'd0);
            check($sformatf("sweep_rd0_a[%0d]", i), 32'(rd_a[0]), 32'd0);
            check($sformatf("sweep_rd1_z[%0d]", i), 32'(rd_z[1]), 32'd0);
            @(negedge clk);
        end
        w = 1'b0;
        #1;
        check("ready_after_sweep_a", 32'(rdy_a), 32'd1);
        check("ready_after_sweep_z", 32'(rdy_z), 32'd1);

        // Directed vector table: dual-port reads, zero register, same-cycle read/write.
        for (int v = 0; v < 10; v++) begin
            w = vecs[v].w; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            ra[0] = vecs[v].ra0; ra[1] = vecs[v].ra1;
            #1;
            check($sformatf("vec%0d_a_p0", v), 32'(rd_a[0]), 32'(vecs[v].e0));
            check($sformatf("vec%0d_a_p1", v), 32'(rd_a[1]), 32'(vecs[v].e1));
            check($sformatf("vec%0d_z_p0", v), 32'(rd_z[0]), 32'(vecs[v].ez0));
            check($sformatf("vec%0d_z_p1", v), 32'(rd_z[1]), 32'(vecs[v].ez1));
            @(negedge clk);
        end

        // Fill every register with index^8'h55 and read all of them back on both ports.
        for (int i = 0; i < 32; i++) begin
            w = 1'b1; waddr = 5'(i); wdata = 8'(i) ^ 8'h55;
            @(negedge clk);
        end
        w = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(31 - i);
            #1;
            check($sformatf("fill_a_r%0d", i), 32'(rd_a[0]), (i == 0) ? 32'd0 : 32'(8'(i) ^ 8'h55));
            check($sformatf("fill_a_r%0d", 31 - i), 32'(rd_a[1]), (i == 31) ? 32'd0 : 32'(8'(31 - i) ^ 8'h55));
            check($sformatf("fill_z_r%0d", i), 32'(rd_z[0]), 32'(8'(i) ^ 8'h55));
            @(negedge clk);
        end

        // One-cycle reset pulse mid-RUN: ready drops after the edge, 32-cycle sweep, array cleared.
        rst = 1'b1;
        #1;
        check("midrun_ready_before_edge", 32'(rdy_a), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            check($sformatf("resweep_ready_a[%0d]", i), 32'(rdy_a), 32'd0);
            @(negedge clk);
        end
        #1;
        check("resweep_done_a", 32'(rdy_a), 32'd1);
        check("resweep_done_z", 32'(rdy_z), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(i);
            #1;
            check($sformatf("cleared_a_r%0d", i), 32'(rd_a[0]), 32'd0);
            check($sformatf("cleared_z_r%0d", i), 32'(rd_z[1]), 32'd0);
            @(negedge clk);
        end

        // Instance B: reset interrupted mid-sweep and held, then a full 16-cycle sweep.
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("b_partial_sweep_ready", 32'(rdy_b), 32'd0);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("b_sweep_ready[%0d]", i), 32'(rdy_b), 32'd0);
            check($sformatf("b_sweep_rd2[%0d]", i), 32'(rd_b[2]), 32'd0);
            @(negedge clk);
        end
        #1;
        check("b_ready_after_sweep", 32'(rdy_b), 32'd1);

        // Fill B with distinct values, then read four different addresses per cycle.
        for (int i = 0; i < 16; i++) begin
            w_b = 1'b1; wa_b = 4'(i); wd_b = 16'hA000 + 16'(i) * 16'h0111;
            sb_b[i] = (i == 0) ? 16'h0000 : (16'hA000 + 16'(i) * 16'h0111);
            @(negedge clk);
        end
        w_b = 1'b0;
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 4; k++) ra_b[k] = 4'((c + 4 * k) % 16);
            #1;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("b_c%0d_p%0d", c, k), 32'(rd_b[k]), 32'(sb_b[(c + 4 * k) % 16]));
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
